// File: rtl/multiplexer_pkg.sv
// Shared types and constants for the 4-to-1 lane selector.
package multiplexer_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 8;
  localparam int unsigned MUX_SEL_WIDTH     = 2;

  // Lane select encoding
  typedef enum logic [MUX_SEL_WIDTH-1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } mux_sel_e;

endpackage : multiplexer_pkg

// File: rtl/mux4_comb.sv
// Purely combinational 4-to-1 lane select; unknown select yields all zeros.
module mux4_comb
  import multiplexer_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         laneA,
  input  logic [WIDTH-1:0]         laneB,
  input  logic [WIDTH-1:0]         laneC,
  input  logic [WIDTH-1:0]         laneD,
  input  logic [MUX_SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]         laneSel_c
);

  // Case-select with a zero default so no latch is inferred and X/Z selects give 0
  always_comb begin
    laneSel_c = '0;
    case (mux_sel_e'(sel))
      SEL_A:   laneSel_c = laneA;
      SEL_B:   laneSel_c = laneB;
      SEL_C:   laneSel_c = laneC;
      SEL_D:   laneSel_c = laneD;
      default: laneSel_c = '0;
    endcase
  end

endmodule : mux4_comb

// File: rtl/multiplexer.sv
// 4-to-1 data selector with a combinational output and a registered copy
// qualified by a valid flag. Optional MULTIPLEXER_PARITY_EN adds a registered
// even-parity bit alongside out_q.
module multiplexer
  import multiplexer_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_c,
  input  logic [WIDTH-1:0]         in_d,
  input  logic [MUX_SEL_WIDTH-1:0] sel,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         val_out,
  output logic [WIDTH-1:0]         out_q,
  output logic [MUX_SEL_WIDTH-1:0] sel_q,
  output logic                     out_valid
`ifdef MULTIPLEXER_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  logic [WIDTH-1:0] laneSel_c;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4Comb (
    .laneA     (in_a),
    .laneB     (in_b),
    .laneC     (in_c),
    .laneD     (in_d),
    .sel       (sel),
    .laneSel_c (laneSel_c)
  );

  assign val_out = laneSel_c;

  // Capture the selected lane on valid; data/select hold otherwise, valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      sel_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= laneSel_c;
        sel_q <= sel;
      end
    end
  end

`ifdef MULTIPLEXER_PARITY_EN
  // Even parity of the captured lane, held alongside out_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (in_valid) begin
      out_parity <= ^laneSel_c;
    end
  end
`endif

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// Directed self-checking bench for multiplexer (8-bit and 16-bit instances).
`timescale 1ns/1ps
module tb_multiplexer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_a, in_b, in_c, in_d;
  logic [1:0]  sel;
  logic        in_valid;
  logic [7:0]  val_out, out_q;
  logic [1:0]  sel_q;
  logic        out_valid;

  logic [15:0] a16, b16, c16, d16;
  logic [1:0]  sel16;
  logic        valid16;
  logic [15:0] valOut16, outQ16;
  logic [1:0]  selQ16;
  logic        outValid16;

`ifdef MULTIPLEXER_PARITY_EN
  logic        out_parity;
  logic        outParity16;
`endif

  int assertCount = 0;
  int failCount   = 0;

  multiplexer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .sel       (sel),
    .in_valid  (in_valid),
    .val_out   (val_out),
    .out_q     (out_q),
    .sel_q     (sel_q),
    .out_valid (out_valid)
`ifdef MULTIPLEXER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  multiplexer #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (a16),
    .in_b      (b16),
    .in_c      (c16),
    .in_d      (d16),
    .sel       (sel16),
    .in_valid  (valid16),
    .val_out   (valOut16),
    .out_q     (outQ16),
    .sel_q     (selQ16),
    .out_valid (outValid16)
`ifdef MULTIPLEXER_PARITY_EN
    ,
    .out_parity(outParity16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_a     = 8'h0A; in_b = 8'h0B; in_c = 8'h0C; in_d = 8'h0D;
    sel      = 2'd0;
    in_valid = 1'b1;
    a16 = 16'h1111; b16 = 16'h2222; c16 = 16'hBEEF; d16 = 16'h4444;
    sel16   = 2'd2;
    valid16 = 1'b0;

    // Reset state, with in_valid high to show reset dominates
    #1;
    checkVal("rst_out_q",     64'(out_q),     64'h0);
    checkVal("rst_sel_q",     64'(sel_q),     64'h0);
    checkVal("rst_out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    checkVal("rst_hold_valid", 64'(out_valid), 64'h0);
    in_valid = 1'b0;

    // Combinational sweep while held in reset
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #10;
      case (i)
        0: checkVal("comb_sel0", 64'(val_out), 64'h0A);
        1: checkVal("comb_sel1", 64'(val_out), 64'h0B);
        2: checkVal("comb_sel2", 64'(val_out), 64'h0C);
        default: checkVal("comb_sel3", 64'(val_out), 64'h0D);
      endcase
    end

    // Release reset and capture lane C
    @(negedge clk);
    rst_n    = 1'b1;
    sel      = 2'd2;
    in_valid = 1'b1;
    valid16  = 1'b1;
    checkVal("w16_comb", 64'(valOut16), 64'hBEEF);
    @(posedge clk); #1;
    checkVal("cap_out_q",     64'(out_q),     64'h0C);
    checkVal("cap_sel_q",     64'(sel_q),     64'h2);
    checkVal("cap_out_valid", 64'(out_valid), 64'h1);
    checkVal("w16_out_q",     64'(outQ16),    64'hBEEF);
    checkVal("w16_sel_q",     64'(selQ16),    64'h2);
    checkVal("w16_valid",     64'(outValid16), 64'h1);
`ifdef MULTIPLEXER_PARITY_EN
    checkVal("par_0c", 64'(out_parity), 64'h0);
`endif

    // Idle cycle: data and select hold, valid drops
    @(negedge clk);
    in_valid = 1'b0;
    valid16  = 1'b0;
    sel      = 2'd0;
    @(posedge clk); #1;
    checkVal("hold_out_q",     64'(out_q),     64'h0C);
    checkVal("hold_sel_q",     64'(sel_q),     64'h2);
    checkVal("hold_out_valid", 64'(out_valid), 64'h0);
    checkVal("w16_hold",       64'(outQ16),    64'hBEEF);
    checkVal("w16_valid_drop", 64'(outValid16), 64'h0);

    // Capture lane D, then asynchronous reset between edges
    @(negedge clk);
    sel      = 2'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    checkVal("capd_out_q",     64'(out_q),     64'h0D);
    checkVal("capd_out_valid", 64'(out_valid), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("arst_out_q",     64'(out_q),     64'h0);
    checkVal("arst_sel_q",     64'(sel_q),     64'h0);
    checkVal("arst_out_valid", 64'(out_valid), 64'h0);
    checkVal("arst_val_out",   64'(val_out),   64'h0D);
    @(posedge clk); #1;
    checkVal("arst_discard", 64'(out_q), 64'h0);

    // First capture after release: lane B (odd parity byte)
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 2'd1;
    @(posedge clk); #1;
    checkVal("first_cap_out_q", 64'(out_q), 64'h0B);
    checkVal("first_cap_sel_q", 64'(sel_q), 64'h1);
`ifdef MULTIPLEXER_PARITY_EN
    checkVal("par_0b", 64'(out_parity), 64'h1);
`endif
    @(negedge clk);
    sel = 2'd2;
    @(posedge clk); #1;
    checkVal("recap_out_q", 64'(out_q), 64'h0C);
`ifdef MULTIPLEXER_PARITY_EN
    checkVal("par_0c_again", 64'(out_parity), 64'h0);
`endif

    // Combinational follow of a data change on the selected lane
    @(negedge clk);
    in_valid = 1'b0;
    sel  = 2'd3;
    #1;
    in_d = 8'h55;
    #1;
    checkVal("comb_d_change", 64'(val_out), 64'h55);
    checkVal("comb_no_cap",   64'(out_q),   64'h0C);

    // Unknown select with all lanes zero gives zero
    in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_d = 8'h00;
    sel  = 2'bxx;
    #1;
    checkVal("sel_x", 64'(val_out), 64'h0);

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_multiplexer
